lr35902_alu_seq: RTL and testbench

- Registered, handshaked successor to the combinational Sharp LR35902 ALU, for use in the multi-cycle CPU datapath.
- Flags are held in an internal F register instead of being driven in by the caller.
- Data width is parametrised.
- Adds a two-pass double-width add (ADD HL,rr style) that chains carry across cycles.
- Valid/ready handshakes on both sides give backpressure toward the register-file writeback.

---
 rtl/lr35902_alu_seq_pkg.sv | 41 ++++
 rtl/lr35902_alu_seq_if.sv | 29 ++
 rtl/lr35902_alu_seq_core.sv | 94 +++++++++
 rtl/lr35902_alu_seq.sv | 111 +++++++++++
 tb/tb_lr35902_alu_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/lr35902_alu_seq_pkg.sv
// Shared types for the registered LR35902 ALU: opcodes, flag register layout, FSM states.
package lr35902_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_ADC   = 4'h1,
      OP_SUB   = 4'h2,
      OP_SBC   = 4'h3,
      OP_AND   = 4'h4,
      OP_XOR   = 4'h5,
      OP_OR    = 4'h6,
      OP_CP    = 4'h7,
      OP_INC   = 4'h8,
      OP_DEC   = 4'h9,
      OP_SWAP  = 4'hA,
      OP_CPL   = 4'hB,
      OP_ADD16 = 4'hC,
      OP_LDF   = 4'hD,
      OP_SCF   = 4'hE,
      OP_CCF   = 4'hF
   } alu_op_t;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC_HI = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   localparam int F_Z_BIT = 3;
   localparam int F_N_BIT = 2;
   localparam int F_H_BIT = 1;
   localparam int F_C_BIT = 0;

endpackage

// File: rtl/lr35902_alu_seq_if.sv
// Request/response handshake bundle between the CPU sequencer and the registered ALU.
interface lr35902_alu_seq_if #(
   parameter int DATA_W = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_op;
   logic [2*DATA_W-1:0]   in_oper_a;
   logic [2*DATA_W-1:0]   in_oper_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*DATA_W-1:0]   out_result;
   logic                  out_flag_zero;
   logic                  out_flag_neg;
   logic                  out_flag_aux_carry;
   logic                  out_flag_carry;

   modport master (
      output in_valid, in_op, in_oper_a, in_oper_b, out_ready,
      input  in_ready, out_valid, out_result,
             out_flag_zero, out_flag_neg, out_flag_aux_carry, out_flag_carry
   );

   modport slave (
      input  in_valid, in_op, in_oper_a, in_oper_b, out_ready,
      output in_ready, out_valid, out_result,
             out_flag_zero, out_flag_neg, out_flag_aux_carry, out_flag_carry
   );
endinterface

// File: rtl/lr35902_alu_seq_core.sv
// Combinational single-pass LR35902 datapath: one DATA_W-bit operation plus its flag update.
module lr35902_alu_core
   import lr35902_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  alu_op_t            op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic               carry_in,
   input  flags_t             f,
   output logic [DATA_W-1:0]  result,
   output flags_t             f_next
);
   localparam int HALF_W = DATA_W / 2;

   logic               use_cin;
   logic [DATA_W-1:0]  b_eff;
   logic [DATA_W:0]    cin_w;
   logic [HALF_W:0]    cin_h;
   logic [DATA_W:0]    sum;
   logic [DATA_W:0]    diff;
   logic [HALF_W:0]    hsum;
   logic [HALF_W:0]    hdiff;

   always_comb begin
      use_cin = (op == OP_ADC) || (op == OP_SBC);
      b_eff   = ((op == OP_INC) || (op == OP_DEC)) ? DATA_W'(1) : b;
      cin_w   = {{DATA_W{1'b0}}, use_cin & carry_in};
      cin_h   = {{HALF_W{1'b0}}, use_cin & carry_in};
      // The extra top bit of each sum/difference is the carry or borrow out
      sum     = {1'b0, a} + {1'b0, b_eff} + cin_w;
      diff    = {1'b0, a} - {1'b0, b_eff} - cin_w;
      hsum    = {1'b0, a[HALF_W-1:0]} + {1'b0, b_eff[HALF_W-1:0]} + cin_h;
      hdiff   = {1'b0, a[HALF_W-1:0]} - {1'b0, b_eff[HALF_W-1:0]} - cin_h;

      result = a;
      f_next = f;
      case (op)
         OP_ADD, OP_ADC, OP_ADD16, OP_INC: begin
            result   = sum[DATA_W-1:0];
            f_next.z = (sum[DATA_W-1:0] == '0);
            f_next.n = 1'b0;
            f_next.h = hsum[HALF_W];
            if (op != OP_INC) f_next.c = sum[DATA_W];
         end
         OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
            result   = (op == OP_CP) ? a : diff[DATA_W-1:0];
            f_next.z = (diff[DATA_W-1:0] == '0);
            f_next.n = 1'b1;
            f_next.h = hdiff[HALF_W];
            if (op != OP_DEC) f_next.c = diff[DATA_W];
         end
         OP_AND: begin
            result = a & b;
            f_next = '{z: ((a & b) == '0), n: 1'b0, h: 1'b1, c: 1'b0};
         end
         OP_XOR: begin
            result = a ^ b;
            f_next = '{z: ((a ^ b) == '0), n: 1'b0, h: 1'b0, c: 1'b0};
         end
         OP_OR: begin
            result = a | b;
            f_next = '{z: ((a | b) == '0), n: 1'b0, h: 1'b0, c: 1'b0};
         end
         OP_SWAP: begin
            result = {a[HALF_W-1:0], a[DATA_W-1:HALF_W]};
            f_next = '{z: (a == '0), n: 1'b0, h: 1'b0, c: 1'b0};
         end
         OP_CPL: begin
            result   = ~a;
            f_next.n = 1'b1;
            f_next.h = 1'b1;
         end
         OP_LDF: begin
            f_next = flags_t'(a[DATA_W-1 -: 4]);
         end
         OP_SCF: begin
            f_next.n = 1'b0;
            f_next.h = 1'b0;
            f_next.c = 1'b1;
         end
         OP_CCF: begin
            f_next.n = 1'b0;
            f_next.h = 1'b0;
            f_next.c = ~f.c;
         end
         default: begin
            result = a;
            f_next = f;
         end
      endcase
   end
endmodule

// File: rtl/lr35902_alu_seq.sv
// Registered, handshaked LR35902 ALU with internal F register and two-pass ADD16.
module lr35902_alu_seq
   import lr35902_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   lr35902_alu_seq_if.slave   bus
);
   state_t              state_q;
   state_t              state_d;
   flags_t              f_q;
   logic [2*DATA_W-1:0] result_q;
   logic [DATA_W-1:0]   lo_p0;
   logic [DATA_W-1:0]   a_hi_p0;
   logic [DATA_W-1:0]   b_hi_p0;
   logic                carry_p0;

   logic                ready;
   logic                valid;
   logic                accept;
   alu_op_t             op_in;
   alu_op_t             core_op;
   logic [DATA_W-1:0]   core_a;
   logic [DATA_W-1:0]   core_b;
   logic                core_cin;
   logic [DATA_W-1:0]   core_result;
   flags_t              core_f;

   assign op_in  = alu_op_t'(bus.in_op);
   assign accept = bus.in_valid & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept)                             state_d = (op_in == OP_ADD16) ? ST_EXEC_HI : ST_HOLD;
            else if (state_q == ST_HOLD && bus.out_ready) state_d = ST_IDLE;
         end
         ST_EXEC_HI: state_d = ST_HOLD;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
      valid = (state_q == ST_HOLD);
   end

   // The single core is time-shared: low pass of ADD16 runs as plain ADD, high pass as ADC on the stash
   always_comb begin
      if (state_q == ST_EXEC_HI) begin
         core_op  = OP_ADC;
         core_a   = a_hi_p0;
         core_b   = b_hi_p0;
         core_cin = carry_p0;
      end else begin
         core_op  = (op_in == OP_ADD16) ? OP_ADD : op_in;
         core_a   = bus.in_oper_a[DATA_W-1:0];
         core_b   = bus.in_oper_b[DATA_W-1:0];
         core_cin = f_q.c;
      end
   end

   lr35902_alu_core #(.DATA_W(DATA_W)) u_core (
      .op       (core_op),
      .a        (core_a),
      .b        (core_b),
      .carry_in (core_cin),
      .f        (f_q),
      .result   (core_result),
      .f_next   (core_f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         f_q      <= '0;
      end else if (state_q == ST_EXEC_HI) begin
         result_q <= {core_result, lo_p0};
         f_q      <= '{z: f_q.z, n: 1'b0, h: core_f.h, c: core_f.c};
      end else if (accept && (op_in != OP_ADD16)) begin
         result_q <= {{DATA_W{1'b0}}, core_result};
         f_q      <= core_f;
      end
   end

   // ADD16 low-pass stash, consumed on the following EXEC_HI edge
   always_ff @(posedge clk) begin
      if (accept && (op_in == OP_ADD16)) begin
         lo_p0    <= core_result;
         carry_p0 <= core_f.c;
         a_hi_p0  <= bus.in_oper_a[2*DATA_W-1:DATA_W];
         b_hi_p0  <= bus.in_oper_b[2*DATA_W-1:DATA_W];
      end
   end

   assign bus.in_ready           = ready;
   assign bus.out_valid          = valid;
   assign bus.out_result         = result_q;
   assign bus.out_flag_zero      = f_q.z;
   assign bus.out_flag_neg       = f_q.n;
   assign bus.out_flag_aux_carry = f_q.h;
   assign bus.out_flag_carry     = f_q.c;
endmodule

// File: tb/tb_lr35902_alu_seq.sv
// Directed self-checking bench for lr35902_alu_seq with hand-computed vectors.
module tb_lr35902_alu_seq;
   import lr35902_alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lr35902_alu_seq_if #(.DATA_W(8)) bus ();

   lr35902_alu_seq #(.DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   wire [3:0] fl = {bus.out_flag_zero, bus.out_flag_neg, bus.out_flag_aux_carry, bus.out_flag_carry};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_oper_a = a;
      bus.in_oper_b = b;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'h0;
      bus.in_oper_a = 16'h0;
      bus.in_oper_b = 16'h0;
      bus.out_ready = 1'b1;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", bus.out_result); end
      checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", fl); end
   endtask

   task automatic test_add_adc();
      send(OP_ADD, 16'h003A, 16'h00C6); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL add_result got %h exp 0000", bus.out_result); end
      checks++; if (fl !== 4'b1011) begin errors++; $display("FAIL add_flags got %b exp 1011", fl); end
      send(OP_ADC, 16'h00E1, 16'h000F); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h00F1) begin errors++; $display("FAIL adc_result got %h exp 00f1", bus.out_result); end
      checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL adc_flags got %b exp 0010", fl); end
   endtask

   task automatic test_cp_dec();
      send(OP_CP, 16'h003C, 16'h002F); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h003C) begin errors++; $display("FAIL cp_result got %h exp 003c", bus.out_result); end
      checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL cp_flags got %b exp 0110", fl); end
      send(OP_DEC, 16'h0001, 16'h0000); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL dec_result got %h exp 0000", bus.out_result); end
      checks++; if (fl !== 4'b1100) begin errors++; $display("FAIL dec_flags got %b exp 1100", fl); end
   endtask

   task automatic test_add16();
      send(OP_ADD16, 16'h8A23, 16'h0605); step(); bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add16_exec_ready got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add16_exec_valid got %b exp 0", bus.out_valid); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add16_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_result !== 16'h9028) begin errors++; $display("FAIL add16_result got %h exp 9028", bus.out_result); end
      checks++; if (fl !== 4'b1010) begin errors++; $display("FAIL add16_flags got %b exp 1010", fl); end
   endtask

   task automatic test_backpressure();
      send(OP_AND, 16'h00F0, 16'h000F); step();
      bus.out_ready = 1'b0;
      send(OP_SCF, 16'h0055, 16'h0000);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", bus.in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b exp 1", i, bus.out_valid); end
         checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL bp_result_%0d got %h exp 0000", i, bus.out_result); end
         checks++; if (fl !== 4'b1010) begin errors++; $display("FAIL bp_flags_%0d got %b exp 1010", i, fl); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready_%0d got %b exp 0", i, bus.in_ready); end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
      step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h0055) begin errors++; $display("FAIL scf_result got %h exp 0055", bus.out_result); end
      checks++; if (fl !== 4'b1001) begin errors++; $display("FAIL scf_flags got %b exp 1001", fl); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.out_valid); end
      checks++; if (fl !== 4'b1001) begin errors++; $display("FAIL idle_flags got %b exp 1001", fl); end
   endtask

   task automatic test_ldf_ccf();
      send(OP_LDF, 16'h00B0, 16'h0000); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h00B0) begin errors++; $display("FAIL ldf_result got %h exp 00b0", bus.out_result); end
      checks++; if (fl !== 4'b1011) begin errors++; $display("FAIL ldf_flags got %b exp 1011", fl); end
      send(OP_CCF, 16'h0012, 16'h0000); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_result !== 16'h0012) begin errors++; $display("FAIL ccf_result got %h exp 0012", bus.out_result); end
      checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL ccf_flags got %b exp 1000", fl); end
   endtask

   task automatic test_misc_ops();
      logic [3:0]  ops  [6] = '{OP_SWAP, OP_CPL, OP_SUB, OP_SBC, OP_XOR, OP_INC};
      logic [15:0] va   [6] = '{16'h00A5, 16'h000F, 16'h0000, 16'h0005, 16'h00FF, 16'h000F};
      logic [15:0] vb   [6] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h00FF, 16'h0000};
      logic [15:0] xres [6] = '{16'h005A, 16'h00F0, 16'h00FF, 16'h0002, 16'h0000, 16'h0010};
      logic [3:0]  xfl  [6] = '{4'b0000, 4'b0110, 4'b0111, 4'b0100, 4'b1000, 4'b0010};
      for (int i = 0; i < 6; i++) begin
         send(ops[i], va[i], vb[i]); step(); bus.in_valid = 1'b0;
         checks++; if (bus.out_result !== xres[i]) begin errors++; $display("FAIL misc_result_%0d got %h exp %h", i, bus.out_result, xres[i]); end
         checks++; if (fl !== xfl[i]) begin errors++; $display("FAIL misc_flags_%0d got %b exp %b", i, fl, xfl[i]); end
      end
   endtask

   task automatic test_add16_wrap();
      send(OP_ADD16, 16'hFFFF, 16'h0001); step(); bus.in_valid = 1'b0;
      step();
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL add16w_result got %h exp 0000", bus.out_result); end
      checks++; if (fl !== 4'b0011) begin errors++; $display("FAIL add16w_flags got %b exp 0011", fl); end
   endtask

   task automatic test_reset_mid();
      send(OP_ADD16, 16'h1234, 16'h1111); step(); bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_exec_valid got %b exp 0", bus.out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL mid_rst_result got %h exp 0000", bus.out_result); end
      checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got %b exp 0000", fl); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_result !== 16'h0000) begin errors++; $display("FAIL post_rst_result got %h exp 0000", bus.out_result); end
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_cp_dec();
      test_add16();
      test_backpressure();
      test_ldf_ccf();
      test_misc_ops();
      test_add16_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
